instr_fetch_unit: RTL and testbench

- Instruction fetch stage; naive_bus master feeding the instruction ROM (or the bus arbiter in front of it).
- Holds the PC and issues word reads.
- Captures the registered read data one cycle after grant and presents {pc, instr} to decode with a valid/stall handshake.
- Accepts branch/jump redirects from execute and discards wrong-path responses.

---
 rtl/ifu_pkg.sv | 12 +
 rtl/naive_bus_if.sv | 24 ++
 rtl/ifu_skid_buf.sv | 45 ++++
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/naive_bus_if.sv
// rtl/naive_bus_if.sv - naive_bus read/write channels with master and slave views
interface naive_bus;

  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;

  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data
  );

endinterface

// File: rtl/ifu_skid_buf.sv
// rtl/ifu_skid_buf.sv - one-entry holding buffer for a fetched {pc, instr} packet
module ifu_skid_buf
  import ifu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       unload_i,
  input  logic       flush_i,
  input  fetch_pkt_t din_i,
  output logic       valid_o,
  output fetch_pkt_t dout_o
);

  logic       valid_q, valid_d;
  fetch_pkt_t data_q, data_d;

  // A load in the same cycle as an unload replaces the departing entry.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = din_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign dout_o  = data_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, bus read issue, response capture and decode handoff
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  naive_bus.master    bus,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        kill_q, kill_d;
  logic        id_valid_q, id_valid_d;
  fetch_pkt_t  id_pkt_q, id_pkt_d;

  logic        grant;
  logic        resp_valid;
  fetch_pkt_t  resp_pkt;
  logic        skid_valid;
  fetch_pkt_t  skid_pkt;
  logic        skid_load, skid_unload, skid_flush;
  logic [1:0]  unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];

  // Only request when the response is guaranteed somewhere to land next cycle.
  assign bus.rd_req  = rst_n && !redirect_valid && !skid_valid
                       && !(inflight_q && id_valid_q && stall_i);
  assign bus.rd_addr = pc_q;
  assign bus.wr_req  = 1'b0;
  assign bus.wr_addr = '0;
  assign bus.wr_data = '0;
  assign bus.wr_be   = '0;

  assign grant      = bus.rd_req && bus.rd_gnt;
  assign resp_valid = inflight_q && !kill_q;
  assign resp_pkt   = '{pc: inflight_pc_q, instr: bus.rd_data};

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = grant;
    inflight_pc_d = grant ? pc_q : inflight_pc_q;
    kill_d        = 1'b0;
    id_valid_d    = id_valid_q;
    id_pkt_d      = id_pkt_q;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_flush    = 1'b0;

    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      kill_d     = inflight_d;
      id_valid_d = 1'b0;
      skid_flush = 1'b1;
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      if (!id_valid_q || !stall_i) begin
        // Skid holds the oldest instruction, so it drains before any response.
        if (skid_valid) begin
          id_valid_d  = 1'b1;
          id_pkt_d    = skid_pkt;
          skid_unload = 1'b1;
          skid_load   = resp_valid;
        end else if (resp_valid) begin
          id_valid_d = 1'b1;
          id_pkt_d   = resp_pkt;
        end else begin
          id_valid_d = 1'b0;
        end
      end else begin
        skid_load = resp_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
      id_valid_q    <= 1'b0;
      id_pkt_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
      id_valid_q    <= id_valid_d;
      id_pkt_q      <= id_pkt_d;
    end
  end

  ifu_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .flush_i  (skid_flush),
    .din_i    (resp_pkt),
    .valid_o  (skid_valid),
    .dout_o   (skid_pkt)
  );

  assign id_valid = id_valid_q;
  assign id_instr = id_pkt_q.instr;
  assign id_pc    = id_pkt_q.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed table, corner sequences and randomized model check
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  naive_bus bus ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .stall_i        (stall_i),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a < 32'h400) ? ((a ^ 32'h5A5A_0000) + INSTR_NOP) : 32'h0;
  endfunction

  // Registered ROM slave: data valid only the cycle after a grant.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rd_data <= 32'h0;
    else        bus.rd_data <= (bus.rd_req && bus.rd_gnt) ? rom(bus.rd_addr) : 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          gnt;
    bit          stall;
    bit          rv;
    logic [31:0] rpc;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_v;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt [24];

  task automatic do_reset();
    rst_n          = 1'b0;
    stall_i        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    bus.rd_gnt     = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_id_valid"}, {31'h0, id_valid}, 32'h0);
    chk({tag, "_id_pc"},    id_pc,            32'h0);
    chk({tag, "_id_instr"}, id_instr,         32'h0);
    chk({tag, "_rd_req"},   {31'h0, bus.rd_req}, 32'h0);
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic        prev_hold, prev_wait;
    logic [31:0] prev_pc, prev_instr, prev_addr;
    int          consumed;

    vt[0]  = '{1, 0, 0, 32'h0,  1, 32'h00, 0, 32'h00};
    vt[1]  = '{1, 0, 0, 32'h0,  1, 32'h04, 0, 32'h00};
    vt[2]  = '{0, 0, 0, 32'h0,  1, 32'h08, 1, 32'h00};
    vt[3]  = '{0, 0, 0, 32'h0,  1, 32'h08, 1, 32'h04};
    vt[4]  = '{0, 0, 0, 32'h0,  1, 32'h08, 0, 32'h00};
    vt[5]  = '{1, 0, 0, 32'h0,  1, 32'h08, 0, 32'h00};
    vt[6]  = '{1, 0, 0, 32'h0,  1, 32'h0C, 0, 32'h00};
    vt[7]  = '{1, 1, 0, 32'h0,  0, 32'h10, 1, 32'h08};
    vt[8]  = '{1, 1, 0, 32'h0,  0, 32'h10, 1, 32'h08};
    vt[9]  = '{1, 1, 0, 32'h0,  0, 32'h10, 1, 32'h08};
    vt[10] = '{1, 1, 0, 32'h0,  0, 32'h10, 1, 32'h08};
    vt[11] = '{1, 0, 0, 32'h0,  0, 32'h10, 1, 32'h08};
    vt[12] = '{1, 0, 0, 32'h0,  1, 32'h10, 1, 32'h0C};
    vt[13] = '{1, 0, 0, 32'h0,  1, 32'h14, 0, 32'h00};
    vt[14] = '{1, 0, 0, 32'h0,  1, 32'h18, 1, 32'h10};
    vt[15] = '{1, 1, 0, 32'h0,  0, 32'h1C, 1, 32'h14};
    vt[16] = '{1, 1, 1, 32'h44, 0, 32'h1C, 1, 32'h14};
    vt[17] = '{1, 0, 0, 32'h0,  1, 32'h44, 0, 32'h00};
    vt[18] = '{1, 0, 0, 32'h0,  1, 32'h48, 0, 32'h00};
    vt[19] = '{1, 0, 0, 32'h0,  1, 32'h4C, 1, 32'h44};
    vt[20] = '{1, 1, 1, 32'h46, 0, 32'h50, 1, 32'h48};
    vt[21] = '{1, 1, 0, 32'h0,  1, 32'h44, 0, 32'h00};
    vt[22] = '{1, 0, 0, 32'h0,  1, 32'h48, 0, 32'h00};
    vt[23] = '{1, 0, 0, 32'h0,  1, 32'h4C, 1, 32'h44};

    do_reset();
    check_reset_state("reset");

    // Directed table: inputs applied after the falling edge, outputs sampled 1ns later.
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      rst_n          = 1'b1;
      bus.rd_gnt     = vt[k].gnt;
      stall_i        = vt[k].stall;
      redirect_valid = vt[k].rv;
      redirect_pc    = vt[k].rpc;
      #1;
      chk($sformatf("tbl%0d_rd_req", k),   {31'h0, bus.rd_req}, {31'h0, vt[k].e_req});
      chk($sformatf("tbl%0d_rd_addr", k),  bus.rd_addr, vt[k].e_addr);
      chk($sformatf("tbl%0d_id_valid", k), {31'h0, id_valid}, {31'h0, vt[k].e_v});
      if (vt[k].e_v) begin
        chk($sformatf("tbl%0d_id_pc", k),    id_pc, vt[k].e_pc);
        chk($sformatf("tbl%0d_id_instr", k), id_instr, rom(vt[k].e_pc));
      end
    end

    // PC wrap past the top of the address space; data beyond the ROM is zero.
    @(negedge clk);
    stall_i = 1'b0; bus.rd_gnt = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    chk("wrap_addr0", bus.rd_addr, 32'hFFFF_FFF8);
    @(negedge clk); #1;
    chk("wrap_addr1", bus.rd_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap_addr2", bus.rd_addr, 32'h0000_0000);
    chk("wrap_id_pc0", id_pc, 32'hFFFF_FFF8);
    chk("wrap_id_instr0", id_instr, 32'h0);
    @(negedge clk); #1;
    chk("wrap_id_pc1", id_pc, 32'hFFFF_FFFC);
    chk("wrap_id_valid1", {31'h0, id_valid}, 32'h1);

    // Fill the skid, then reset asynchronously mid-cycle.
    @(negedge clk);
    stall_i = 1'b1; #1;
    chk("pre_rst_id_pc", id_pc, 32'h0);
    @(negedge clk); #1;
    chk("skid_full_rd_req", {31'h0, bus.rd_req}, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    stall_i = 1'b0;
    rst_n   = 1'b1; #1;
    chk("rst_refetch_addr", bus.rd_addr, 32'h0);
    @(negedge clk); #1;
    chk("rst_refetch_v1", {31'h0, id_valid}, 32'h0);
    @(negedge clk); #1;
    chk("rst_refetch_v2", {31'h0, id_valid}, 32'h1);
    chk("rst_refetch_pc", id_pc, 32'h0);

    // Randomized run against an in-order stream model.
    do_reset();
    @(negedge clk);
    rst_n      = 1'b1;
    exp_pc     = 32'h0;
    prev_hold  = 1'b0;
    prev_wait  = 1'b0;
    prev_pc    = 32'h0;
    prev_instr = 32'h0;
    prev_addr  = 32'h0;
    consumed   = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.rd_gnt     = ($urandom_range(0, 9) < 7);
      stall_i        = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 99) < 5);
      redirect_pc    = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      #1;
      if (prev_hold) begin
        chk("rnd_hold_valid", {31'h0, id_valid}, 32'h1);
        chk("rnd_hold_pc", id_pc, prev_pc);
        chk("rnd_hold_instr", id_instr, prev_instr);
      end
      if (prev_wait) chk("rnd_addr_hold", bus.rd_addr, prev_addr);
      if (redirect_valid) begin
        chk("rnd_redirect_rd_req", {31'h0, bus.rd_req}, 32'h0);
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (id_valid && !stall_i) begin
        chk("rnd_order_pc", id_pc, exp_pc);
        chk("rnd_instr", id_instr, rom(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      prev_hold  = id_valid && stall_i && !redirect_valid;
      prev_wait  = bus.rd_req && !bus.rd_gnt && !redirect_valid;
      prev_pc    = id_pc;
      prev_instr = id_instr;
      prev_addr  = bus.rd_addr;
    end
    chk("rnd_progress", {31'h0, (consumed >= 300)}, 32'h1);
    chk("wr_req_zero", {31'h0, bus.wr_req}, 32'h0);
    chk("wr_data_zero", bus.wr_data | bus.wr_addr | {28'h0, bus.wr_be}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
